// File: rtl/bilinear_pkg.sv
// Shared fixed-point constants and intermediate-width helpers for the bilinear SIMD pipeline.
// All functions are constant-foldable so they can size localparams in the modules.
package bilinear_pkg;

    function automatic int one_val(input int frac_w);
        return 1 << frac_w;
    endfunction

    function automatic int half_val(input int frac_w);
        return 1 << (frac_w - 1);
    endfunction

    // Added before the final 2*FRAC_W right shift to get round-half-up.
    function automatic int rnd_const(input int frac_w);
        return 1 << (2 * frac_w - 1);
    endfunction

    function automatic int lerp_w(input int xw, input int frac_w);
        return xw + frac_w + 1;
    endfunction

    function automatic int top_w(input int pix_w, input int frac_w);
        return lerp_w(pix_w, frac_w);
    endfunction

    function automatic int v_w(input int pix_w, input int frac_w);
        return lerp_w(top_w(pix_w, frac_w), frac_w);
    endfunction

endpackage

// File: rtl/bilinear_lerp.sv
// One full-precision two-point lerp: y = x0*(ONE-f) + x1*f, with f already clamped to [0, ONE].
// Purely combinational; the caller owns the pipeline register.
module bilinear_lerp
    import bilinear_pkg::*;
#(
    parameter int XW     = 8,
    parameter int FRAC_W = 8
) (
    input  logic [XW-1:0]      x0,
    input  logic [XW-1:0]      x1,
    input  logic [FRAC_W:0]    f,
    output logic [XW+FRAC_W:0] y
);

    localparam int              YW    = lerp_w(XW, FRAC_W);
    localparam logic [FRAC_W:0] ONE_F = (FRAC_W + 1)'(one_val(FRAC_W));

    logic [FRAC_W:0] f_c;

    always_comb begin
        f_c = ONE_F - f;
        y   = YW'(x0) * YW'(f_c) + YW'(x1) * YW'(f);
    end

endmodule

// File: rtl/bilinear_simd_pipe.sv
// N-lane bilinear / nearest-neighbour interpolator: S1 horizontal lerp, S2 vertical lerp,
// S3 round-half-up and saturate. Single global stall; bubbles travel with the beats.
module bilinear_simd_pipe
    import bilinear_pkg::*;
#(
    parameter int N      = 4,
    parameter int PIX_W  = 8,
    parameter int COEF_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       mode,
    input  logic [N-1:0]               lane_en,
    input  logic [N-1:0][PIX_W-1:0]    p00,
    input  logic [N-1:0][PIX_W-1:0]    p01,
    input  logic [N-1:0][PIX_W-1:0]    p10,
    input  logic [N-1:0][PIX_W-1:0]    p11,
    input  logic [N-1:0][COEF_W-1:0]   a,
    input  logic [N-1:0][COEF_W-1:0]   b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0][PIX_W-1:0]    pixel_out,
    output logic [N-1:0]               lane_valid,
    output logic [31:0]                out_count
);

    localparam int                TW      = top_w(PIX_W, FRAC_W);
    localparam int                VW      = v_w(PIX_W, FRAC_W);
    localparam int                SH      = 2 * FRAC_W;
    localparam logic [COEF_W-1:0] ONE_C   = COEF_W'(one_val(FRAC_W));
    localparam logic [COEF_W-1:0] HALF_C  = COEF_W'(half_val(FRAC_W));
    localparam logic [VW:0]       RND     = (VW + 1)'(rnd_const(FRAC_W));
    localparam logic [VW:0]       PIX_MAX = (VW + 1)'((1 << PIX_W) - 1);

    // Handshake: a beat moves on a side when valid && ready are both high at the rising edge.
    // Every stage advances together on adv; the only stall source is a held output beat.
    logic adv;

    logic                    s1_valid_q, s1_mode_q;
    logic [N-1:0]            s1_en_q;
    logic [N-1:0][TW-1:0]    s1_top_d, s1_top_q;
    logic [N-1:0][TW-1:0]    s1_bot_d, s1_bot_q;
    logic [N-1:0][FRAC_W:0]  s1_b_d, s1_b_q;
    logic [N-1:0][PIX_W-1:0] s1_nn_d, s1_nn_q;

    logic                    s2_valid_q, s2_mode_q;
    logic [N-1:0]            s2_en_q;
    logic [N-1:0][VW-1:0]    s2_v_d, s2_v_q;
    logic [N-1:0][PIX_W-1:0] s2_nn_q;

    logic                    out_valid_q;
    logic [N-1:0][PIX_W-1:0] pixel_out_d, pixel_out_q;
    logic [N-1:0]            lane_valid_d, lane_valid_q;
    logic [31:0]             out_count_d, out_count_q;

    assign adv        = !(out_valid_q && !out_ready);
    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign pixel_out  = pixel_out_q;
    assign lane_valid = lane_valid_q;
    assign out_count  = out_count_q;

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [FRAC_W:0]  a_cl, b_cl;
        logic [TW-1:0]    top, bot;
        logic [VW-1:0]    v;
        logic [PIX_W-1:0] nn;
        logic [VW:0]      rnd_sum, rnd_shift;
        logic [PIX_W-1:0] rounded, pix;

        // Fractions at or above ONE are pinned to exactly ONE before any multiply.
        always_comb begin
            a_cl = (a[i] >= ONE_C) ? ONE_C[FRAC_W:0] : a[i][FRAC_W:0];
            b_cl = (b[i] >= ONE_C) ? ONE_C[FRAC_W:0] : b[i][FRAC_W:0];
        end

        always_comb begin
            nn = p00[i];
            case ({b[i] >= HALF_C, a[i] >= HALF_C})
                2'b00:   nn = p00[i];
                2'b01:   nn = p01[i];
                2'b10:   nn = p10[i];
                default: nn = p11[i];
            endcase
        end

        bilinear_lerp #(.XW(PIX_W), .FRAC_W(FRAC_W)) u_lerp_top (
            .x0 (p00[i]),
            .x1 (p01[i]),
            .f  (a_cl),
            .y  (top)
        );

        bilinear_lerp #(.XW(PIX_W), .FRAC_W(FRAC_W)) u_lerp_bot (
            .x0 (p10[i]),
            .x1 (p11[i]),
            .f  (a_cl),
            .y  (bot)
        );

        bilinear_lerp #(.XW(TW), .FRAC_W(FRAC_W)) u_lerp_vert (
            .x0 (s1_top_q[i]),
            .x1 (s1_bot_q[i]),
            .f  (s1_b_q[i]),
            .y  (v)
        );

        always_comb begin
            rnd_sum   = {1'b0, s2_v_q[i]} + RND;
            rnd_shift = rnd_sum >> SH;
            rounded   = (rnd_shift > PIX_MAX) ? {PIX_W{1'b1}} : rnd_shift[PIX_W-1:0];
            pix       = '0;
            if (s2_valid_q && s2_en_q[i]) begin
                pix = s2_mode_q ? s2_nn_q[i] : rounded;
            end
        end

        assign s1_top_d[i]    = top;
        assign s1_bot_d[i]    = bot;
        assign s1_b_d[i]      = b_cl;
        assign s1_nn_d[i]     = nn;
        assign s2_v_d[i]      = v;
        assign pixel_out_d[i] = pix;
    end

    always_comb begin
        lane_valid_d = s2_valid_q ? s2_en_q : '0;
        out_count_d  = out_count_q + 32'(out_valid_q && out_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_en_q      <= '0;
            s1_top_q     <= '0;
            s1_bot_q     <= '0;
            s1_b_q       <= '0;
            s1_nn_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_en_q      <= '0;
            s2_v_q       <= '0;
            s2_nn_q      <= '0;
            out_valid_q  <= 1'b0;
            pixel_out_q  <= '0;
            lane_valid_q <= '0;
            out_count_q  <= '0;
        end else begin
            if (adv) begin
                s1_valid_q   <= in_valid;
                s1_mode_q    <= mode;
                s1_en_q      <= lane_en;
                s1_top_q     <= s1_top_d;
                s1_bot_q     <= s1_bot_d;
                s1_b_q       <= s1_b_d;
                s1_nn_q      <= s1_nn_d;
                s2_valid_q   <= s1_valid_q;
                s2_mode_q    <= s1_mode_q;
                s2_en_q      <= s1_en_q;
                s2_v_q       <= s2_v_d;
                s2_nn_q      <= s1_nn_q;
                out_valid_q  <= s2_valid_q;
                pixel_out_q  <= pixel_out_d;
                lane_valid_q <= lane_valid_d;
            end
            out_count_q <= out_count_d;
        end
    end

endmodule

// File: tb/tb_bilinear_simd_pipe.sv
// Scoreboard bench for bilinear_simd_pipe: reference model at input accept, compare at output handshake.
module tb_bilinear_simd_pipe;

    localparam int N  = 4;
    localparam int PW = 8;
    localparam int CW = 16;
    localparam int EW = N + N * PW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [N-1:0]         lane_en;
    logic [N-1:0][PW-1:0] p00, p01, p10, p11;
    logic [N-1:0][CW-1:0] a, b;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0][PW-1:0] pixel_out;
    logic [N-1:0]         lane_valid;
    logic [31:0]          out_count;

    logic [EW-1:0] exp_q[$];
    int            acc_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            sent    = 0;
    bit            check_lat = 0;
    bit            hold_pend = 0;
    logic [EW:0]   held;
    bit            rnd_done;

    bilinear_simd_pipe #(.N(N), .PIX_W(PW), .COEF_W(CW), .FRAC_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .lane_en    (lane_en),
        .p00        (p00),
        .p01        (p01),
        .p10        (p10),
        .p11        (p11),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pixel_out  (pixel_out),
        .lane_valid (lane_valid),
        .out_count  (out_count)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_px(int q00, int q01, int q10, int q11, int qa, int qb,
                                    bit md, bit en);
        longint ac, bc, top, bot, v, r;
        if (!en) return 0;
        if (md) begin
            if (qb >= 128) return (qa >= 128) ? q11 : q10;
            return (qa >= 128) ? q01 : q00;
        end
        ac  = (qa >= 256) ? 256 : qa;
        bc  = (qb >= 256) ? 256 : qb;
        top = q00 * (256 - ac) + q01 * ac;
        bot = q10 * (256 - ac) + q11 * ac;
        v   = top * (256 - bc) + bot * bc;
        r   = (v + 32768) >>> 16;
        if (r > 255) r = 255;
        return int'(r);
    endfunction

    function automatic logic [EW-1:0] model_beat();
        logic [N-1:0][PW-1:0] px;
        for (int i = 0; i < N; i++) begin
            px[i] = PW'(model_px(p00[i], p01[i], p10[i], p11[i], a[i], b[i], mode, lane_en[i]));
        end
        return {lane_en, px};
    endfunction

    // scoreboard: push on input accept, pop on output handshake, check hold while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model_beat());
                acc_q.push_back(cyc);
                sent++;
            end
            if (hold_pend) chk("hold", {lane_valid, pixel_out, out_valid}, held);
            hold_pend = out_valid && !out_ready;
            held      = {lane_valid, pixel_out, out_valid};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_beat", 1, 0);
                end else begin
                    int ac;
                    logic [EW-1:0] e;
                    e  = exp_q.pop_front();
                    ac = acc_q.pop_front();
                    chk("beat", {lane_valid, pixel_out}, e);
                    if (check_lat) chk("latency", cyc - ac, 3);
                end
            end
        end
    end

    // driver tasks
    task automatic set_uniform(int q00, int q01, int q10, int q11, int qa, int qb,
                               bit md, logic [N-1:0] en);
        for (int i = 0; i < N; i++) begin
            p00[i] = PW'(q00); p01[i] = PW'(q01); p10[i] = PW'(q10); p11[i] = PW'(q11);
            a[i] = CW'(qa); b[i] = CW'(qb);
        end
        mode = md;
        lane_en = en;
    endtask

    task automatic set_random();
        for (int i = 0; i < N; i++) begin
            p00[i] = PW'($urandom_range(0, 255)); p01[i] = PW'($urandom_range(0, 255));
            p10[i] = PW'($urandom_range(0, 255)); p11[i] = PW'($urandom_range(0, 255));
            a[i] = CW'($urandom_range(0, 400)); b[i] = CW'($urandom_range(0, 400));
        end
        mode = 1'($urandom_range(0, 1));
        lane_en = N'($urandom_range(0, (1 << N) - 1));
    endtask

    task automatic send();
        bit acc;
        int guard = 0;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 200);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            g++;
        end
        #1;
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        set_uniform(0, 0, 0, 0, 0, 0, 0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_lane_valid", lane_valid, 0);
        chk("rst_out_count", out_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        check_lat = 1;
        set_uniform(100, 120, 140, 160, 128, 128, 0, 4'hF); send();
        wait_drain();
        check_lat = 0;
        set_uniform(50, 150, 100, 200, 64, 192, 0, 4'hF);   send();
        set_uniform(10, 20, 30, 200, 300, 300, 0, 4'hF);    send();
        set_uniform(77, 20, 30, 200, 0, 0, 0, 4'hF);        send();
        set_uniform(11, 22, 33, 44, 128, 127, 1, 4'hF);     send();
        set_uniform(100, 120, 140, 160, 128, 128, 0, 4'b0101); send();
        wait_drain();
        chk("count_directed", out_count, sent);

        sent = 0;
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    set_uniform(10 * k, 20 + k, 255 - k, 7 * k, 25 * k, 300 - 20 * k, k[0], 4'hF);
                    send();
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("count_b2b", out_count, 10);

        rnd_done = 0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    set_random();
                    send();
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();
        chk("count_random", out_count, sent);

        set_uniform(100, 120, 140, 160, 128, 128, 0, 4'hF); send();
        set_uniform(50, 150, 100, 200, 64, 192, 0, 4'hF);   send();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_flight_out_valid", out_valid, 0);
        chk("rst_flight_count", out_count, 0);
        chk("rst_flight_lane_valid", lane_valid, 0);
        chk("rst_flight_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        sent = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_count", out_count, 0);

        check_lat = 1;
        set_uniform(100, 120, 140, 160, 128, 128, 0, 4'hF); send();
        wait_drain();
        chk("final_count", out_count, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bilinear_simd_pipe.md
BILINEAR_SIMD_PIPE -- requirements
Module: bilinear_simd_pipe

Interface
REQ-001 SHALL have parameter N, default 4: number of SIMD lanes, 1..16.
REQ-002 SHALL have parameter PIX_W, default 8: pixel width, unsigned.
REQ-003 SHALL have parameter COEF_W, default 16: coefficient width, unsigned fixed point.
REQ-004 SHALL have parameter FRAC_W, default 8: fractional bits of a/b (Q8.8 at defaults); ONE = 1<<FRAC_W.
REQ-005 SHALL have port clk  in  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid  in  1  input beat valid.
REQ-008 SHALL have port in_ready  out  1  block accepts beat this cycle.
REQ-009 SHALL have port mode  in  1  0 = bilinear, 1 = nearest-neighbour; captured per beat.
REQ-010 SHALL have port lane_en  in  N  per-lane enable; captured per beat.
REQ-011 SHALL have ports p00, p01, p10, p11  in  N x PIX_W  corner pixels per lane.
REQ-012 SHALL have ports a, b  in  N x COEF_W  horizontal/vertical fractions per lane.
REQ-013 SHALL have port out_valid  out  1  result beat valid.
REQ-014 SHALL have port out_ready  in  1  downstream accepts result.
REQ-015 SHALL have port pixel_out  out  N x PIX_W  interpolated pixels.
REQ-016 SHALL have port lane_valid  out  N  lane_en of the beat now on the output.
REQ-017 SHALL have port out_count  out  32  number of completed output handshakes.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready; SHALL emit when out_valid && out_ready.
REQ-019 SHALL be a 3-stage pipeline: S1 horizontal lerp, S2 vertical lerp, S3 round/saturate; latency 3 cycles from accept to out_valid with no stall.
REQ-020 SHALL use one global advance enable = !(out_valid && !out_ready); in_ready = enable; bubbles are not collapsed.
REQ-021 SHALL sustain 1 beat/cycle while out_ready is held high.
REQ-022 SHALL hold pixel_out, lane_valid, out_valid stable while out_valid && !out_ready.
REQ-023 SHALL clamp any a or b >= ONE to ONE before use.
REQ-024 S1 SHALL compute top = p00*(ONE-a)+p01*a and bot = p10*(ONE-a)+p11*a, full precision (PIX_W+FRAC_W+1 bits).
REQ-025 S2 SHALL compute v = top*(ONE-b)+bot*b, full precision, no truncation.
REQ-026 S3 SHALL compute (v + (1<<(2*FRAC_W-1))) >> 2*FRAC_W (round half up), saturated to 2^PIX_W-1.
REQ-027 In mode 1 a lane SHALL output p00/p01/p10/p11 selected by (b >= ONE/2, a >= ONE/2), with the same latency and handshake.
REQ-028 A lane with lane_en=0 SHALL output 0 and lane_valid=0 for that beat.
REQ-029 out_count SHALL increment by 1 per output handshake and wrap from 2^32-1 to 0.
REQ-030 Simultaneous input accept and output handshake SHALL both complete in the same cycle.

Reset
REQ-031 rst_n low SHALL immediately clear all stage valids, out_valid=0, pixel_out=0, lane_valid=0, out_count=0.
REQ-032 Beats in flight at reset SHALL be discarded; no output beat for them after release.
REQ-033 in_ready SHALL be 1 during and after reset (pipeline empty).

Structure
REQ-034 Package bilinear_pkg SHALL hold ONE, HALF, rounding constant, and intermediate width localparam functions.
REQ-035 Sub-module bilinear_lerp SHALL implement one 2-point lerp (x0*(ONE-f)+x1*f); instantiated 2x per lane in S1, 1x in S2.
REQ-036 Lanes SHALL be produced with a generate loop; no lane shares arithmetic with another.

Verification
REQ-037 All lanes p=100,120,140,160, a=b=128, mode 0 -> pixel_out 130 on every lane, 3 cycles after accept.
REQ-038 p=50,150,100,200, a=64, b=192 -> 113 (exact 112.5, round half up).
REQ-039 a=b=300 (clamped), p11=200 -> 200; a=b=0 -> p00; mode 1 with a=128, b=127 -> p01.
REQ-040 10 back-to-back beats, out_ready low cycles 4-6 -> no beat lost or duplicated, outputs held, out_count=10.
REQ-041 lane_en=4'b0101 -> lanes 1,3 output 0, lane_valid=0101.
REQ-042 rst_n low with 2 beats in flight -> out_valid=0 immediately, no output for those beats, out_count=0.
